boron_key_schedule_round: RTL and testbench

//   One round of the BORON-80 key schedule: takes the current 80-bit key register

---
 rtl/boron_key_schedule_round_if.sv | 18 +
 rtl/boron_key_schedule_round.sv | 50 +++++
 tb/tb_boron_key_schedule_round.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/boron_key_schedule_round_if.sv
// Key-schedule round bus: round constant and current key in, registered next key out.
interface boron_key_schedule_round_if;
   logic [4:0]  round_counter;
   logic [79:0] i_ks_oldkey;
   logic [79:0] o_ks_newkey;

   modport master (
      output round_counter,
      output i_ks_oldkey,
      input  o_ks_newkey
   );

   modport slave (
      input  round_counter,
      input  i_ks_oldkey,
      output o_ks_newkey
   );
endinterface

// File: rtl/boron_key_schedule_round.sv
// BORON-80 key schedule round: rotate left 13, S-box low nibble, XOR RC into bits 63:59.
// One-cycle registered latency; no handshake, a new result is loaded on every clock edge.
module boron_key_schedule_round (
   input  logic                          clk,
   input  logic                          rst,
   boron_key_schedule_round_if.slave     ks
);

   logic [79:0] rot;
   logic [79:0] next_key;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE;
         4'h1: y = 4'h4;
         4'h2: y = 4'hB;
         4'h3: y = 4'h1;
         4'h4: y = 4'h7;
         4'h5: y = 4'h9;
         4'h6: y = 4'hC;
         4'h7: y = 4'hA;
         4'h8: y = 4'hD;
         4'h9: y = 4'h2;
         4'hA: y = 4'h0;
         4'hB: y = 4'hF;
         4'hC: y = 4'h8;
         4'hD: y = 4'h5;
         4'hE: y = 4'h3;
         default: y = 4'h6;
      endcase
      return y;
   endfunction

   always_comb begin
      rot             = {ks.i_ks_oldkey[66:0], ks.i_ks_oldkey[79:67]};
      next_key        = rot;
      next_key[3:0]   = sbox(rot[3:0]);
      next_key[63:59] = rot[63:59] ^ ks.round_counter;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ks.o_ks_newkey <= 80'h0;
      end else begin
         ks.o_ks_newkey <= next_key;
      end
   end

endmodule

// File: tb/tb_boron_key_schedule_round.sv
// Self-checking bench for boron_key_schedule_round using an expected-value queue.
module tb_boron_key_schedule_round;

   logic clk;
   logic rst;
   boron_key_schedule_round_if ks_bus();

   boron_key_schedule_round dut (
      .clk (clk),
      .rst (rst),
      .ks  (ks_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total;
   int          passed;
   logic [79:0] exp_q[$];
   logic [79:0] got;
   logic [79:0] expv;

   // Independent reference: bitwise rotate, table S-box, bitwise RC XOR.
   function automatic logic [79:0] model(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      logic [3:0]  sb [0:15];
      sb = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
             4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
      t = '0;
      for (int i = 0; i < 80; i++) t[(i + 13) % 80] = k[i];
      t[3:0] = sb[t[3:0]];
      for (int j = 0; j < 5; j++) t[59 + j] = t[59 + j] ^ rc[j];
      return t;
   endfunction

   task automatic drive(input logic [79:0] k, input logic [4:0] rc, input logic [79:0] e);
      @(negedge clk);
      ks_bus.i_ks_oldkey   = k;
      ks_bus.round_counter = rc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(80'h1, 5'h0, model(80'h1, 5'h0));
      got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
      if (got !== expv) $display("FAIL reset_preload got=%h exp=%h", got, expv);
      else passed++;
      #1 rst = 1'b1;
      #1;
      got = ks_bus.o_ks_newkey; total++;
      if (got !== 80'h0) $display("FAIL reset_async got=%h exp=%h", got, 80'h0);
      else passed++;
      ks_bus.i_ks_oldkey = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      got = ks_bus.o_ks_newkey; total++;
      if (got !== 80'h0) $display("FAIL reset_hold got=%h exp=%h", got, 80'h0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      drive(80'h0, 5'h01, 80'h0000_0800_0000_0000_000E);
      got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
      if (got !== expv) $display("FAIL reset_release got=%h exp=%h", got, expv);
      else passed++;
   endtask

   task automatic test_vectors();
      logic [79:0] keys [0:4];
      logic [4:0]  rcs  [0:4];
      logic [79:0] exps [0:4];
      keys = '{80'h0, 80'h1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
               80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h8000_0000_0000_0000_0000};
      rcs  = '{5'h01, 5'h00, 5'h00, 5'h1F, 5'h00};
      exps = '{80'h0000_0800_0000_0000_000E, 80'h0000_0000_0000_0000_200E,
               80'hFFFF_FFFF_FFFF_FFFF_FFF6, 80'hFFFF_07FF_FFFF_FFFF_FFF6,
               80'h0000_0000_0000_0000_100E};
      for (int v = 0; v < 5; v++) begin
         drive(keys[v], rcs[v], exps[v]);
         got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
         if (got !== expv) $display("FAIL vector%0d got=%h exp=%h", v, got, expv);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [79:0] k;
      logic [4:0]  rc;
      for (int n = 0; n < 20; n++) begin
         k  = {$urandom(), $urandom(), $urandom()};
         rc = 5'($urandom_range(0, 31));
         drive(k, rc, model(k, rc));
         got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
         if (got !== expv) $display("FAIL random%0d got=%h exp=%h", n, got, expv);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [79:0] k;
      logic [4:0]  rc_list [0:7];
      rc_list = '{5'd0, 5'd31, 5'd26, 5'd1, 5'd25, 5'd16, 5'd8, 5'd0};
      for (int n = 0; n < 8; n++) begin
         k = {16'hA5A5, 32'(n * 32'h1111_1111), 32'h0F0F_0F00 | 32'(n)};
         drive(k, rc_list[n], model(k, rc_list[n]));
         got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
         if (got !== expv) $display("FAIL b2b%0d got=%h exp=%h", n, got, expv);
         else passed++;
      end
   endtask

   task automatic test_feedback_chain();
      logic [79:0] key0;
      logic [79:0] mkey;
      logic        restart;
      key0    = 80'h0123_4567_89AB_CDEF_1357;
      mkey    = key0;
      restart = 1'b1;
      for (int rc = 1; rc <= 25; rc++) begin
         if (restart) drive(key0, 5'(rc), model(mkey, 5'(rc)));
         else         drive(ks_bus.o_ks_newkey, 5'(rc), model(mkey, 5'(rc)));
         restart = 1'b0;
         mkey = model(mkey, 5'(rc));
         got = ks_bus.o_ks_newkey; expv = exp_q.pop_front(); total++;
         if (got !== expv) $display("FAIL chain_rc%0d got=%h exp=%h", rc, got, expv);
         else passed++;
         if (rc == 12) begin
            #1 rst = 1'b1;
            #1;
            got = ks_bus.o_ks_newkey; total++;
            if (got !== 80'h0) $display("FAIL chain_reset got=%h exp=%h", got, 80'h0);
            else passed++;
            @(negedge clk);
            rst     = 1'b0;
            mkey    = key0;
            restart = 1'b1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      total  = 0;
      passed = 0;
      rst    = 1'b0;
      ks_bus.i_ks_oldkey   = 80'h0;
      ks_bus.round_counter = 5'h0;
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_feedback_chain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
